note_queue: RTL and testbench

NOTE_QUEUE -- requirements
Module: note_queue

---
 rtl/note_queue.sv | 114 +++++++++++
 tb/tb_note_queue.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/note_queue.sv
// Note lookahead queue: holds upcoming notes in a small FIFO, tracks the
// past/current note, and publishes a frame-stable {past, current, future}
// snapshot to the display stage at each vsync falling edge.
module note_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      note_valid,
    input  logic [5:0]                note_in,
    input  logic                      note_advance,
    input  logic                      vsync,
    output logic [17:0]               buffer,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned NW = 6;

    logic [NW-1:0] mem_q [DEPTH];

    logic [NW-1:0] past_q,     past_d;
    logic [NW-1:0] current_q,  current_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [CW-1:0] count_q,    count_d;
    logic          full_q,     full_d;
    logic          overflow_q, overflow_d;
    logic          vsync_dly_q, vsync_dly_d;
    logic [17:0]   buffer_q,   buffer_d;

    logic          push;
    logic          pop;
    logic          frame_edge;
    logic [NW-1:0] future;

    // A full queue still accepts a note when the same cycle pops one.
    assign push       = note_valid && ((count_q != CW'(DEPTH)) || note_advance);
    assign pop        = note_advance && (count_q != '0);
    assign future     = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign frame_edge = vsync_dly_q && !vsync;

    // Next-state computation for pointers, counters, note registers and snapshot.
    always_comb begin
        past_d      = past_q;
        current_d   = current_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        vsync_dly_d = vsync;
        buffer_d    = buffer_q;

        if (note_advance) begin
            past_d    = current_q;
            current_d = future;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
        full_d  = (count_d == CW'(DEPTH));
        if (note_valid && !push) begin
            overflow_d = 1'b1;
        end
        if (frame_edge) begin
            buffer_d = {past_q, current_q, future};
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            past_q      <= '0;
            current_q   <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            vsync_dly_q <= 1'b0;
            buffer_q    <= '0;
        end else begin
            past_q      <= past_d;
            current_q   <= current_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            vsync_dly_q <= vsync_dly_d;
            buffer_q    <= buffer_d;
        end
    end

    // FIFO storage; contents are unreachable after reset since count is 0.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= note_in;
        end
    end

    assign buffer   = buffer_q;
    assign count    = count_q;
    assign full     = full_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_note_queue.sv
// Scoreboard bench for note_queue: stimulus pushes expected output state,
// a negedge monitor pops and compares against the DUT.
module tb_note_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          note_valid = 1'b0;
    logic [5:0]    note_in = '0;
    logic          note_advance = 1'b0;
    logic          vsync = 1'b0;
    logic [17:0]   buffer;
    logic [CW-1:0] count;
    logic          full;
    logic          overflow;

    always #5 clk = ~clk;

    note_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .note_valid   (note_valid),
        .note_in      (note_in),
        .note_advance (note_advance),
        .vsync        (vsync),
        .buffer       (buffer),
        .count        (count),
        .full         (full),
        .overflow     (overflow)
    );

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          fl;
        logic          ovf;
        logic [17:0]   bv;
    } exp_t;

    exp_t  expq[$];
    string nameq[$];
    int    vectors = 0;
    int    miscompares = 0;
    exp_t  e;
    string nm_m;

    // Monitor: compare every pending expectation against the DUT state.
    always @(negedge clk) begin
        while (expq.size() > 0) begin
            e    = expq.pop_front();
            nm_m = nameq.pop_front();
            vectors++;
            if ({count, full, overflow, buffer} !== e) begin
                miscompares++;
                $display("FAIL %s: got count=%0d full=%0b ovf=%0b buffer=%h, want count=%0d full=%0b ovf=%0b buffer=%h",
                         nm_m, count, full, overflow, buffer, e.cnt, e.fl, e.ovf, e.bv);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input logic rst, input logic v, input int n, input logic a, input logic vs);
        reset        = rst;
        note_valid   = v;
        note_in      = 6'(n);
        note_advance = a;
        vsync        = vs;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        note_valid   = 1'b0;
        note_advance = 1'b0;
    endtask

    task automatic chk(input string nm, input int c, input logic f, input logic o,
                       input int p, input int cu, input int fu);
        exp_t x;
        x.cnt = CW'(c);
        x.fl  = f;
        x.ovf = o;
        x.bv  = {6'(p), 6'(cu), 6'(fu)};
        expq.push_back(x);
        nameq.push_back(nm);
    endtask

    task automatic do_reset();  cyc(1'b1, 1'b0, 0, 1'b0, 1'b0); endtask
    task automatic push(input int n); cyc(1'b0, 1'b1, n, 1'b0, 1'b0); endtask
    task automatic adv();       cyc(1'b0, 1'b0, 0, 1'b1, 1'b0); endtask
    task automatic frame();
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    int mq[$];
    int mp, mc, mf, mbp, mbc, mbf;

    initial begin
        // Reset state
        do_reset();
        chk("reset", 0, 0, 0, 0, 0, 0);

        // Fill / drain with frame snapshots
        push(5);  chk("fill1", 1, 0, 0, 0, 0, 0);
        push(7);  chk("fill2", 2, 0, 0, 0, 0, 0);
        push(9);  chk("fill3", 3, 0, 0, 0, 0, 0);
        frame();  chk("fill_frame", 3, 0, 0, 0, 0, 5);
        adv();    chk("adv1", 2, 0, 0, 0, 0, 5);
        frame();  chk("adv1_frame", 2, 0, 0, 0, 5, 7);
        adv();    chk("adv2", 1, 0, 0, 0, 5, 7);
        frame();  chk("frame_579", 1, 0, 0, 5, 7, 9);
        adv();    chk("hold_after_adv", 0, 0, 0, 5, 7, 9);
        frame();  chk("drain_frame", 0, 0, 0, 7, 9, 0);
        adv();    chk("adv_empty", 0, 0, 0, 7, 9, 0);
        frame();  chk("adv_empty_frame", 0, 0, 0, 9, 0, 0);

        // Overflow
        do_reset();
        chk("reset2", 0, 0, 0, 0, 0, 0);
        push(1);  chk("ov_p1", 1, 0, 0, 0, 0, 0);
        push(2);  chk("ov_p2", 2, 0, 0, 0, 0, 0);
        push(3);  chk("ov_p3", 3, 0, 0, 0, 0, 0);
        push(4);  chk("ov_full", 4, 1, 0, 0, 0, 0);
        push(5);  chk("ov_drop", 4, 1, 1, 0, 0, 0);
        adv(); frame(); chk("ov_out1", 3, 0, 1, 0, 1, 2);
        adv(); frame(); chk("ov_out2", 2, 0, 1, 1, 2, 3);
        adv(); frame(); chk("ov_out3", 1, 0, 1, 2, 3, 4);
        adv(); frame(); chk("ov_out4", 0, 0, 1, 3, 4, 0);
        adv(); frame(); chk("ov_rest", 0, 0, 1, 4, 0, 0);

        // Simultaneous push and advance
        do_reset();
        cyc(1'b0, 1'b1, 12, 1'b1, 1'b0);
        chk("sim_empty", 1, 0, 0, 0, 0, 0);
        frame();  chk("sim_empty_frame", 1, 0, 0, 0, 0, 12);
        push(13); push(14); push(15);
        chk("sim_fill", 4, 1, 0, 0, 0, 12);
        cyc(1'b0, 1'b1, 20, 1'b1, 1'b0);
        chk("sim_full", 4, 1, 0, 0, 0, 12);
        frame();  chk("sim_full_frame", 4, 1, 0, 0, 12, 13);
        adv(); frame(); chk("sim_o1", 3, 0, 0, 12, 13, 14);
        adv(); frame(); chk("sim_o2", 2, 0, 0, 13, 14, 15);
        adv(); frame(); chk("sim_o3", 1, 0, 0, 14, 15, 20);
        adv(); frame(); chk("sim_last_out", 0, 0, 0, 15, 20, 0);

        // Reset mid-operation, overriding push, advance and frame edge
        do_reset();
        push(3); push(4); push(5);
        frame();  chk("mid_frame", 3, 0, 0, 0, 0, 3);
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 9, 1'b1, 1'b0);
        chk("reset_mid", 0, 0, 0, 0, 0, 0);
        push(8);  chk("after_reset_push", 1, 0, 0, 0, 0, 0);
        adv();    chk("after_reset_adv", 0, 0, 0, 0, 0, 0);
        frame();  chk("after_reset_frame", 0, 0, 0, 0, 8, 0);

        // Pointer wrap against a queue reference
        do_reset();
        mq.delete();
        mp = 0; mc = 0; mbp = 0; mbc = 0; mbf = 0;
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < (r % 3) + 1; i++) begin
                if (mq.size() < DEPTH) begin
                    push(10 + r * 3 + i);
                    mq.push_back(10 + r * 3 + i);
                    chk("wrap_push", mq.size(), mq.size() == DEPTH, 0, mbp, mbc, mbf);
                end
            end
            for (int j = 0; j < (r % 2) + 1; j++) begin
                adv();
                mp = mc;
                mc = (mq.size() > 0) ? mq.pop_front() : 0;
                frame();
                mf  = (mq.size() > 0) ? mq[0] : 0;
                mbp = mp; mbc = mc; mbf = mf;
                chk("wrap_adv", mq.size(), mq.size() == DEPTH, 0, mbp, mbc, mbf);
            end
        end

        repeat (2) @(posedge clk);
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
